// File: rtl/img_capture.sv
// rtl/img_capture.sv - snoops the pixel stream and writes one rectangular window into the image buffer
module img_capture #(
    parameter int RECT_WIDTH  = 128,
    parameter int RECT_LENGTH = 128,
    parameter int COL_BITS    = 7,
    parameter int ROW_BITS    = 7
) (
    input  logic                         pclk,
    input  logic                         rst,
    input  logic [10:0]                  hcount_in,
    input  logic [10:0]                  vcount_in,
    input  logic                         hblnk_in,
    input  logic                         vblnk_in,
    input  logic [11:0]                  rgb_in,
    input  logic [10:0]                  xpos,
    input  logic [10:0]                  ypos,
    input  logic                         start,
    input  logic                         abort,
    output logic                         wr_en,
    output logic [ROW_BITS+COL_BITS-1:0] wr_addr,
    output logic [11:0]                  wr_data,
    output logic                         busy,
    output logic                         done,
    output logic                         partial
);

    localparam int CNT_BITS = ROW_BITS + COL_BITS + 1;
    localparam logic [CNT_BITS-1:0] TOTAL = CNT_BITS'(RECT_WIDTH * RECT_LENGTH);
    localparam logic [11:0] W12 = 12'(RECT_WIDTH);
    localparam logic [11:0] L12 = 12'(RECT_LENGTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE
    } state_t;

    state_t                        state_q, state_d;
    logic [10:0]                   x_q, x_d;
    logic [10:0]                   y_q, y_d;
    logic [CNT_BITS-1:0]           cnt_q, cnt_d;
    logic                          wr_en_q, wr_en_d;
    logic [ROW_BITS+COL_BITS-1:0]  wr_addr_q, wr_addr_d;
    logic [11:0]                   wr_data_q, wr_data_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          partial_q, partial_d;

    logic        origin;
    logic        eligible;
    logic        take_pixel;
    logic        finish_partial;
    logic [11:0] h12, v12, x12, y12;
    logic [11:0] col_off, row_off;
    logic [CNT_BITS-1:0] cnt_inc;

    // Window bounds are compared at 12 bits so that X+W near the top of the 11-bit range cannot wrap.
    always_comb begin
        h12      = {1'b0, hcount_in};
        v12      = {1'b0, vcount_in};
        x12      = {1'b0, x_q};
        y12      = {1'b0, y_q};
        col_off  = h12 - x12;
        row_off  = v12 - y12;
        origin   = (hcount_in == 11'd0) && (vcount_in == 11'd0);
        eligible = !hblnk_in && !vblnk_in &&
                   (h12 >= x12) && (h12 < x12 + W12) &&
                   (v12 >= y12) && (v12 < y12 + L12);
        cnt_inc  = cnt_q + CNT_BITS'(1);
    end

    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        y_d            = y_q;
        cnt_d          = cnt_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        done_d         = 1'b0;
        partial_d      = 1'b0;
        take_pixel     = 1'b0;
        finish_partial = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The cycle showing done still belongs to the finished capture.
                if (start && !done_q) begin
                    x_d     = xpos;
                    y_d     = ypos;
                    cnt_d   = '0;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (abort) begin
                    finish_partial = 1'b1;
                end else if (origin) begin
                    state_d    = S_CAPTURE;
                    take_pixel = 1'b1;
                end
            end
            S_CAPTURE: begin
                // A second origin means the frame ended with the window not fully visible.
                if (abort || origin) begin
                    finish_partial = 1'b1;
                end else begin
                    take_pixel = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (finish_partial) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            partial_d = 1'b1;
        end

        if (take_pixel && eligible) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {row_off[ROW_BITS-1:0], col_off[COL_BITS-1:0]};
            wr_data_d = rgb_in;
            cnt_d     = cnt_inc;
            if (cnt_inc == TOTAL) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            partial_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            partial_q <= partial_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign partial = partial_q;

endmodule

// File: tb/tb_img_capture.sv
// tb/tb_img_capture.sv - scoreboard bench for img_capture on a reduced 64x40 timing with a 16x8 window
module tb_img_capture;

    localparam int RW = 16, RL = 8, CB = 4, RB = 3, AW = CB + RB;
    localparam int H_TOT = 64, H_VIS = 48, V_TOT = 40, V_VIS = 30;

    logic          pclk, rst;
    logic [10:0]   hcount_in, vcount_in, xpos, ypos;
    logic          hblnk_in, vblnk_in, start, abort;
    logic [11:0]   rgb_in;
    logic          wr_en, busy, done, partial;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;

    img_capture #(.RECT_WIDTH(RW), .RECT_LENGTH(RL), .COL_BITS(CB), .ROW_BITS(RB)) dut (
        .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
        .start(start), .abort(abort), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .partial(partial)
    );

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [11:0]   data;
        bit            done;
        bit            partial;
        bit            chk_pos;
        int            h;
        int            v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_err = 0;
    int   h_cnt = 0, v_cnt = 0;
    int   prev_h = 0, prev_v = 0;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic drive_stream();
        hcount_in = 11'(h_cnt);
        vcount_in = 11'(v_cnt);
        hblnk_in  = (h_cnt >= H_VIS);
        vblnk_in  = (v_cnt >= V_VIS);
        rgb_in    = {6'(v_cnt), 6'(h_cnt)};
    endtask

    initial begin
        drive_stream();
        forever begin
            @(posedge pclk);
            #1;
            if (h_cnt == H_TOT - 1) begin
                h_cnt = 0;
                v_cnt = (v_cnt == V_TOT - 1) ? 0 : v_cnt + 1;
            end else begin
                h_cnt = h_cnt + 1;
            end
            drive_stream();
        end
    end

    // Position of the pixel sampled at the last edge, used to check the one-cycle write latency.
    always @(posedge pclk) begin
        prev_h <= int'(hcount_in);
        prev_v <= int'(vcount_in);
    end

    always @(negedge pclk) begin
        exp_t e;
        bit   ok;
        if (rst && (wr_en || done)) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: wr_en=%0b addr=%h data=%h done=%0b partial=%0b, required no output",
                         wr_en, wr_addr, wr_data, done, partial);
            end else begin
                e  = sb.pop_front();
                ok = (wr_en == e.wr) && (done == e.done) && (partial == e.partial) &&
                     (busy == !e.done) &&
                     (!e.wr || (wr_addr == e.addr && wr_data == e.data)) &&
                     (!e.chk_pos || (prev_h == e.h && prev_v == e.v));
                if (!ok) begin
                    n_err++;
                    $display("FAIL scoreboard: got wr=%0b addr=%h data=%h done=%0b partial=%0b busy=%0b pos=(%0d,%0d), required wr=%0b addr=%h data=%h done=%0b partial=%0b busy=%0b pos=(%0d,%0d)",
                             wr_en, wr_addr, wr_data, done, partial, busy, prev_h, prev_v,
                             e.wr, e.addr, e.data, e.done, e.partial, !e.done, e.h, e.v);
                end
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic fail_bound(string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic wait_pos(int h, int v);
        int k = 0;
        do begin
            @(posedge pclk);
            #2;
            k++;
        end while (!(h_cnt == h && v_cnt == v) && k < 6000);
        if (k >= 6000) fail_bound("wait_pos");
    endtask

    task automatic pulse_start(int x, int y, logic busy_req, string name);
        xpos  = 11'(x);
        ypos  = 11'(y);
        start = 1'b1;
        @(posedge pclk);
        #2;
        start = 1'b0;
        check(name, 32'(busy), 32'(busy_req));
    endtask

    task automatic push_window(int x, int y, int cols, int rows, bit last_done, int nmax);
        exp_t e;
        int   n = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                if (n < nmax) begin
                    e.wr      = 1'b1;
                    e.addr    = {3'(r), 4'(c)};
                    e.data    = {6'(y + r), 6'(x + c)};
                    e.done    = last_done && (r == rows - 1) && (c == cols - 1);
                    e.partial = 1'b0;
                    e.chk_pos = 1'b1;
                    e.h       = x + c;
                    e.v       = y + r;
                    sb.push_back(e);
                    n++;
                end
            end
        end
    endtask

    task automatic push_partial(bit chk_pos, int h, int v);
        exp_t e;
        e.wr      = 1'b0;
        e.addr    = '0;
        e.data    = '0;
        e.done    = 1'b1;
        e.partial = 1'b1;
        e.chk_pos = chk_pos;
        e.h       = h;
        e.v       = v;
        sb.push_back(e);
    endtask

    task automatic drain(string name);
        int k = 0;
        while (sb.size() != 0 && k < 8000) begin
            @(posedge pclk);
            k++;
        end
        if (sb.size() != 0) begin
            fail_bound(name);
            sb.delete();
        end
        @(posedge pclk);
        #2;
    endtask

    task automatic wait_done(string name);
        int k = 0;
        do begin
            @(negedge pclk);
            k++;
        end while (!done && k < 8000);
        if (k >= 8000) fail_bound(name);
    endtask

    initial begin
        repeat (95000) @(posedge pclk);
        $display("FAIL watchdog: simulation cycle budget exhausted");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        int nw;
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        xpos  = '0;
        ypos  = '0;

        // Reset held while the stream runs: every output must be zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check("reset_outputs", {26'd0, wr_en, busy, done, partial, |wr_addr, |wr_data}, 32'd0);
        end
        @(posedge pclk);
        #2;
        rst = 1'b1;
        repeat (200) @(posedge pclk);
        #2;
        check("idle_busy", 32'(busy), 32'd0);

        // Full window, armed mid-frame.
        wait_pos(0, 20);
        push_window(10, 5, RW, RL, 1'b1, RW * RL);
        pulse_start(10, 5, 1'b1, "busy_after_start");
        drain("full_window");

        // Origin pixel itself is captured.
        wait_pos(5, 3);
        push_window(0, 0, RW, RL, 1'b1, RW * RL);
        pulse_start(0, 0, 1'b1, "busy_origin_test");
        drain("origin_window");

        // Window clipped by blanking: 8x4 writes, partial done at the next origin.
        wait_pos(0, 35);
        push_window(40, 26, 8, 4, 1'b0, 32);
        push_partial(1'b1, 0, 0);
        pulse_start(40, 26, 1'b1, "busy_clipped");
        wait_done("clipped_done");
        xpos  = 11'd9;
        ypos  = 11'd9;
        start = 1'b1;
        @(posedge pclk);
        #2;
        start = 1'b0;
        check("start_in_done_cycle_ignored", 32'(busy), 32'd0);

        // Start in the following cycle is accepted; abort after 20 writes.
        push_window(4, 2, RW, RL, 1'b0, 20);
        push_partial(1'b0, 0, 0);
        pulse_start(4, 2, 1'b1, "start_after_done_accepted");
        nw = 0;
        for (int k = 0; k < 8000 && nw < 20; k++) begin
            @(negedge pclk);
            if (wr_en) nw++;
        end
        if (nw < 20) fail_bound("abort_write_count");
        abort = 1'b1;
        @(posedge pclk);
        #2;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        drain("abort");
        repeat (50) @(posedge pclk);
        #2;
        abort = 1'b1;
        @(posedge pclk);
        #2;
        abort = 1'b0;
        repeat (5) @(posedge pclk);
        #2;
        check("abort_in_idle_busy", 32'(busy), 32'd0);

        // Start with a new window during capture is ignored.
        wait_pos(0, 25);
        push_window(20, 10, RW, RL, 1'b1, RW * RL);
        pulse_start(20, 10, 1'b1, "busy_restart_test");
        wait_pos(30, 12);
        pulse_start(0, 0, 1'b1, "busy_during_ignored_start");
        drain("ignored_restart");
        repeat (H_TOT * V_TOT + 100) @(posedge pclk);
        #2;
        check("final_idle_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
